// File: rtl/vec_mul_sequencer.sv
// Job controller for the vector-multiply datapath: pops a weight tile, reloads the
// PE array, streams len UB reads and issues latency-aligned Results-SRAM writes.
module vec_mul_sequencer #(
  parameter int ADDRESSSIZE  = 10,
  parameter int PIPE_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic [ADDRESSSIZE-1:0] len,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   ub_read_valid,
  output logic                   result_write_en,
  output logic [ADDRESSSIZE-1:0] result_address,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_WAIT = 3'd1,
    W_POP  = 3'd2,
    W_LOAD = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5,
    FIN    = 3'd6
  } state_t;

  localparam logic [ADDRESSSIZE-1:0] ONE = ADDRESSSIZE'(1);

  state_t                  state;
  state_t                  state_d;
  logic                    accept;
  logic [ADDRESSSIZE-1:0]  src_q;
  logic [ADDRESSSIZE-1:0]  len_q;
  logic [ADDRESSSIZE-1:0]  rd_idx;
  logic [ADDRESSSIZE-1:0]  wr_idx;
  logic [PIPE_LATENCY-1:0] vld_p;

  // busy is the registered copy of the previous state, so gating on it keeps a
  // start from being taken while the outputs still advertise the old job
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !busy) begin
          if (len == '0) begin
            state_d = FIN;
          end else begin
            state_d = W_WAIT;
            accept  = 1'b1;
          end
        end
      end
      W_WAIT:  if (!fifo_empty) state_d = W_POP;
      W_POP:   state_d = W_LOAD;
      W_LOAD:  state_d = STREAM;
      STREAM:  if (rd_idx == len_q - ONE) state_d = DRAIN;
      DRAIN:   if (wr_idx == len_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      ub_read_valid    <= 1'b0;
      ub_address       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      src_q            <= '0;
      len_q            <= '0;
      rd_idx           <= '0;
      wr_idx           <= '0;
      result_address   <= '0;
      vld_p            <= '0;
    end else begin
      state <= state_d;

      // output stage: every strobe is a registered decode of the current state
      fifo_read_enable <= (state == W_POP);
      weight_reload    <= (state == W_LOAD);
      ub_read_valid    <= (state == STREAM);
      ub_address       <= (state == STREAM) ? src_q + rd_idx : '0;
      busy             <= (state != IDLE);
      done             <= (state == FIN);

      if (state == W_LOAD) begin
        rd_idx <= '0;
      end else if (state == STREAM) begin
        rd_idx <= rd_idx + ONE;
      end

      // write stage: read-valid delayed to line up with datapath results
      vld_p[0] <= ub_read_valid;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end

      if (result_write_en) begin
        wr_idx         <= wr_idx + ONE;
        result_address <= result_address + ONE;
      end

      if (accept) begin
        src_q          <= src_base;
        len_q          <= len;
        wr_idx         <= '0;
        result_address <= dst_base;
      end
    end
  end

  assign result_write_en = vld_p[PIPE_LATENCY-1];

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Bench for vec_mul_sequencer: a job-level timeline model predicts every output per
// cycle; directed scenarios plus random jobs, with literal checks on recorded events.
module tb_vec_mul_sequencer;
  localparam int AW = 10;
  localparam int PL = 2;
  localparam int NC = 16384;
  localparam int AMOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [AW-1:0] len;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic          weight_reload;
  logic [AW-1:0] ub_address;
  logic          ub_read_valid;
  logic          result_write_en;
  logic [AW-1:0] result_address;
  logic          busy;
  logic          done;

  vec_mul_sequencer #(.ADDRESSSIZE(AW), .PIPE_LATENCY(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .len(len), .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable),
    .weight_reload(weight_reload), .ub_address(ub_address), .ub_read_valid(ub_read_valid),
    .result_write_en(result_write_en), .result_address(result_address),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected value of each output, indexed by cycle
  bit e_fre[NC];
  bit e_rl[NC];
  bit e_ubv[NC];
  bit e_we[NC];
  bit e_busy[NC];
  bit e_done[NC];
  int e_ua[NC];
  int e_wa[NC];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int d_last = 0;
  int last_a = 0;

  int q_ua[$];
  int q_wa[$];
  int n_pop, n_rl, n_done;
  int c_pop, c_rd, c_wr, c_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_log();
    q_ua.delete();
    q_wa.delete();
    n_pop = 0; n_rl = 0; n_done = 0;
    c_pop = -1; c_rd = -1; c_wr = -1; c_done = -1;
  endtask

  task automatic clear_exp(input int from);
    for (int c = from; c < NC; c++) begin
      e_fre[c] = 0; e_rl[c] = 0; e_ubv[c] = 0; e_we[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_ua[c] = 0; e_wa[c] = 0;
    end
  endtask

  // job accepted in cycle a; the FIFO first shows non-empty in cycle a+1+stall
  task automatic fill_job(input int a, input int s, input int dd, input int l,
                          input int stall, output int d);
    int w;
    w = a + 1 + stall;
    d = (l == 0) ? a + 2 : w + 6 + PL + l;
    if (d + 1 >= NC) begin
      $display("FAIL model_range cyc=%0d got=%0d want=<%0d", cyc, d, NC);
      $fatal(1, "cycle budget exceeded");
    end
    if (l == 0) begin
      e_busy[d] = 1;
    end else begin
      for (int c = a + 2; c <= d; c++) e_busy[c] = 1;
      e_fre[w+2] = 1;
      e_rl[w+3]  = 1;
      for (int i = 0; i < l; i++) begin
        e_ubv[w+4+i]   = 1;
        e_ua[w+4+i]    = (s + i) % AMOD;
        e_we[w+4+PL+i] = 1;
        e_wa[w+4+PL+i] = (dd + i) % AMOD;
      end
    end
    e_done[d] = 1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && cyc < NC) begin
        chk("fifo_read_enable", fifo_read_enable, e_fre[cyc]);
        chk("weight_reload", weight_reload, e_rl[cyc]);
        chk("ub_read_valid", ub_read_valid, e_ubv[cyc]);
        chk("result_write_en", result_write_en, e_we[cyc]);
        chk("busy", busy, e_busy[cyc]);
        chk("done", done, e_done[cyc]);
        if (e_ubv[cyc]) chk("ub_address", ub_address, e_ua[cyc]);
        if (e_we[cyc]) chk("result_address", result_address, e_wa[cyc]);
        if (fifo_read_enable === 1'b1) begin n_pop++; if (c_pop < 0) c_pop = cyc; end
        if (weight_reload === 1'b1) n_rl++;
        if (ub_read_valid === 1'b1) begin q_ua.push_back(int'(ub_address)); if (c_rd < 0) c_rd = cyc; end
        if (result_write_en === 1'b1) begin q_wa.push_back(int'(result_address)); if (c_wr < 0) c_wr = cyc; end
        if (done === 1'b1) begin n_done++; if (c_done < 0) c_done = cyc; end
      end
    end
  end

  task automatic run_job(input int s, input int dd, input int l, input int stall,
                         input bit glitch, input int abort);
    int a, d, gc;
    while (cyc <= d_last) begin @(posedge clk); #1; end
    a = cyc;
    last_a = a;
    start = 1'b1;
    src_base = AW'(s); dst_base = AW'(dd); len = AW'(l);
    fifo_empty = 1'($urandom);
    fill_job(a, s, dd, l, stall, d);
    gc = glitch ? int'($urandom_range(d, a + 1)) : -1;
    while (cyc < d) begin
      @(posedge clk); #1;
      if (abort != 0 && cyc == a + abort) begin
        rst = 1'b1;
        start = 1'b0;
        clear_exp(cyc + 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        d_last = cyc - 1;
        return;
      end
      start = (cyc == gc);
      src_base = AW'($urandom); dst_base = AW'($urandom); len = AW'($urandom);
      if (cyc <= a + stall) fifo_empty = 1'b1;
      else if (cyc == a + 1 + stall) fifo_empty = 1'b0;
      else fifo_empty = 1'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    d_last = d;
  endtask

  initial begin
    int exp_u[3];
    int exp_w[3];
    int l, nd;
    rst = 1'b1; start = 1'b0; fifo_empty = 1'b1;
    src_base = '0; dst_base = '0; len = '0;
    clear_log();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ub_address", ub_address, 0);
    chk("reset_result_address", result_address, 0);
    d_last = cyc + 3;

    // basic job
    clear_log();
    run_job(5, 20, 4, 0, 1'b0, 0);
    chk("s2_pops", n_pop, 1);
    chk("s2_reloads", n_rl, 1);
    chk("s2_dones", n_done, 1);
    chk("s2_pop_lat", c_pop - last_a, 3);
    chk("s2_wr_after_rd", c_wr - c_rd, PL);
    chk("s2_reads", q_ua.size(), 4);
    chk("s2_writes", q_wa.size(), 4);
    for (int i = 0; i < 4 && i < q_ua.size(); i++) chk("s2_ub_addr", q_ua[i], 5 + i);
    for (int i = 0; i < 4 && i < q_wa.size(); i++) chk("s2_res_addr", q_wa[i], 20 + i);

    // FIFO stall of 10 cycles
    clear_log();
    run_job(5, 20, 4, 10, 1'b0, 0);
    chk("s3_pop_lat", c_pop - last_a, 13);
    chk("s3_reads", q_ua.size(), 4);
    for (int i = 0; i < 4 && i < q_wa.size(); i++) chk("s3_res_addr", q_wa[i], 20 + i);
    chk("s3_dones", n_done, 1);

    // address wrap
    clear_log();
    exp_u = '{1022, 1023, 0};
    exp_w = '{1023, 0, 1};
    run_job(1022, 1023, 3, 0, 1'b0, 0);
    chk("s4_reads", q_ua.size(), 3);
    chk("s4_writes", q_wa.size(), 3);
    for (int i = 0; i < 3 && i < q_ua.size(); i++) chk("s4_ub_addr", q_ua[i], exp_u[i]);
    for (int i = 0; i < 3 && i < q_wa.size(); i++) chk("s4_res_addr", q_wa[i], exp_w[i]);

    // zero-length job, then a job with a start issued while busy
    clear_log();
    run_job(7, 9, 0, 0, 1'b0, 0);
    chk("s5_pops", n_pop, 0);
    chk("s5_reads", q_ua.size(), 0);
    chk("s5_writes", q_wa.size(), 0);
    chk("s5_done_lat", c_done - last_a, 2);
    clear_log();
    run_job(100, 200, 4, 1, 1'b1, 0);
    chk("s5_glitch_writes", q_wa.size(), 4);
    chk("s5_glitch_dones", n_done, 1);

    // reset after two reads, then a clean single-vector job
    clear_log();
    run_job(30, 40, 6, 0, 1'b0, 6);
    chk("s6_reads", q_ua.size(), 2);
    chk("s6_writes", q_wa.size(), 0);
    chk("s6_busy", busy, 0);
    clear_log();
    run_job(50, 60, 1, 0, 1'b0, 0);
    chk("s6_new_writes", q_wa.size(), 1);
    if (q_wa.size() > 0) chk("s6_new_addr", q_wa[0], 60);
    chk("s6_new_dones", n_done, 1);

    // random jobs
    for (int j = 0; j < 24; j++) begin
      clear_log();
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      run_job(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)), l,
              int'($urandom_range(0, 5)), 1'($urandom), 0);
      chk("rnd_writes", q_wa.size(), l);
      nd = n_done;
      chk("rnd_dones", nd, 1);
    end

    // maximum length
    clear_log();
    run_job(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)), AMOD - 1,
            2, 1'b1, 0);
    chk("max_writes", q_wa.size(), AMOD - 1);

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
